// File: rtl/enc_pkg.sv
// Constants and types shared by the encrypter-array paralleliser and result serializer,
// so both sides agree on lane count, packet width and nibble framing.
package enc_pkg;

  localparam int NIBBLE_W            = 4;
  localparam int DEF_NUM_ENCRYPTERS  = 4;
  localparam int DEF_ENCRYPTER_WIDTH = 32;

  typedef enum logic [0:0] {
    SH_EMPTY,
    SH_SENDING
  } sh_state_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qspi_result_serializer_if.sv
// Encrypter-array result lanes plus the 4-bit transmit handshake.
// master = environment (encrypters and downstream sink), slave = serializer.
interface qspi_result_serializer_if
  import enc_pkg::*;
#(
  parameter int NUM = DEF_NUM_ENCRYPTERS,
  parameter int W   = DEF_ENCRYPTER_WIDTH
);

  logic [NUM*W-1:0]    enc_data;
  logic [NUM-1:0]      enc_valid;
  logic [NUM-1:0]      enc_ack;
  logic [NIBBLE_W-1:0] qspi_data;
  logic                qspi_valid;
  logic                qspi_ready;

  modport master (
    output enc_data, enc_valid, qspi_ready,
    input  enc_ack, qspi_data, qspi_valid
  );

  modport slave (
    input  enc_data, enc_valid, qspi_ready,
    output enc_ack, qspi_data, qspi_valid
  );

endinterface

// File: rtl/qspi_result_serializer_shifter.sv
// Nibble shift register: a loaded packet is presented one nibble per beat, LSB first; first beat
// visible the cycle after load; valid/data hold stable while qspi_ready is low.
module qspi_nibble_shifter
  import enc_pkg::*;
#(
  parameter int W      = DEF_ENCRYPTER_WIDTH,
  parameter int BEAT_W = clog2_min1(W / NIBBLE_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [W-1:0]        load_dat_i,
  input  logic                qspi_ready_i,
  output logic [NIBBLE_W-1:0] qspi_data_o,
  output logic                qspi_valid_o,
  output logic                last_beat_o,
  output logic [BEAT_W-1:0]   beat_o
);

  localparam int BEATS = W / NIBBLE_W;
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

  sh_state_t                        state_q, state_d;
  logic [BEATS-1:0][NIBBLE_W-1:0]   shift_q, shift_d;
  logic [BEAT_W-1:0]                beat_q, beat_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SH_EMPTY;
      shift_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
    end
  end

  // The owner only asserts load_i when empty or when the last beat leaves this edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    if (clear_i) begin
      state_d = SH_EMPTY;
      beat_d  = '0;
    end else if (load_i) begin
      state_d = SH_SENDING;
      shift_d = load_dat_i;
      beat_d  = '0;
    end else if (state_q == SH_SENDING && qspi_ready_i) begin
      if (beat_q == LAST) begin
        state_d = SH_EMPTY;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    qspi_valid_o = (state_q == SH_SENDING);
    qspi_data_o  = '0;
    last_beat_o  = 1'b0;
    if (state_q == SH_SENDING) begin
      qspi_data_o = shift_q[beat_q];
      last_beat_o = (beat_q == LAST);
    end
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/qspi_result_serializer.sv
// Round-robin collector of encrypter results into a one-entry holding buffer feeding the nibble
// shifter; capture to first beat is 2 cycles, back-to-back packets without bubbles under ready=1.
module qspi_result_serializer
  import enc_pkg::*;
#(
  parameter int NUM_ENCRYPTERS  = DEF_NUM_ENCRYPTERS,
  parameter int ENCRYPTER_WIDTH = DEF_ENCRYPTER_WIDTH,
  parameter int IDX_W           = clog2_min1(NUM_ENCRYPTERS),
  parameter int BEAT_W          = clog2_min1(ENCRYPTER_WIDTH / NIBBLE_W)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  qspi_result_serializer_if.slave        bus,
  output logic                           busy,
  output logic [IDX_W-1:0]               lane_index_out,
  output logic [BEAT_W-1:0]              beat_index_out
);

  localparam int W = ENCRYPTER_WIDTH;
  localparam logic [IDX_W-1:0] LANE_LAST = IDX_W'(NUM_ENCRYPTERS - 1);

  logic [IDX_W-1:0]          lane_q, lane_d;
  logic                      hold_full_q, hold_full_d;
  logic [W-1:0]              hold_q, hold_d;
  logic [NUM_ENCRYPTERS-1:0] ack_q, ack_d;

  logic [W-1:0] lane_dat;
  logic         sh_valid, sh_last, sh_free;
  logic         load, capture;

  assign lane_dat = bus.enc_data[int'(lane_q)*W +: W];

  // Holding buffer may refill on the same edge it drains into the shifter.
  assign sh_free = !sh_valid || (sh_last && bus.qspi_ready);
  assign load    = hold_full_q && sh_free && !clear;
  assign capture = bus.enc_valid[lane_q] && (!hold_full_q || load) && !clear;

  always_comb begin
    lane_d      = lane_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    ack_d       = '0;
    if (clear) begin
      lane_d      = '0;
      hold_full_d = 1'b0;
    end else if (capture) begin
      hold_d        = lane_dat;
      hold_full_d   = 1'b1;
      ack_d[lane_q] = 1'b1;
      lane_d        = (lane_q == LANE_LAST) ? '0 : lane_q + IDX_W'(1);
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q      <= '0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      ack_q       <= '0;
    end else begin
      lane_q      <= lane_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      ack_q       <= ack_d;
    end
  end

  qspi_nibble_shifter #(
    .W      (W),
    .BEAT_W (BEAT_W)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear),
    .load_i       (load),
    .load_dat_i   (hold_q),
    .qspi_ready_i (bus.qspi_ready),
    .qspi_data_o  (bus.qspi_data),
    .qspi_valid_o (sh_valid),
    .last_beat_o  (sh_last),
    .beat_o       (beat_index_out)
  );

  assign bus.qspi_valid = sh_valid;
  assign bus.enc_ack    = ack_q;
  assign busy           = hold_full_q || sh_valid;
  assign lane_index_out = lane_q;

endmodule
